// File: rtl/pico_pkg.sv
// pico_pkg: shared definitions for the picoMIPS control-and-execute core.
//   - opcode_t   : 3-bit instruction opcodes
//   - alu_func_t : 2-bit ALU function select
//   - field-position constants, given as offsets below the instruction MSB
//     so they hold for any data width.
package pico_pkg;

  localparam int OPC_W = 3;  // opcode field width
  localparam int REG_W = 3;  // register-address field width

  // The opcode field occupies [Isize-1 -: OPC_W].
  // R1 follows it and starts OPC_W bits below the MSB.
  // R2 starts OPC_W+REG_W bits below the MSB.
  localparam int R1_OFS = OPC_W;
  localparam int R2_OFS = OPC_W + REG_W;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_MULI = 3'b100,
    OP_MUL  = 3'b101,
    OP_LDSW = 3'b110,
    OP_WAIT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_MUL  = 2'b11
  } alu_func_t;

endpackage

// File: rtl/pico_alu.sv
// pico_alu: purely combinational ALU.
// Ports:
//   func   in  alu_func_t : operation select
//   a      in  n          : first operand
//   b      in  n          : second operand
//   result out n          : result
//
// The operations are as follows:
//   - PASS returns b.
//   - ADD and SUB wrap modulo 2^n.
//   - MUL is a signed Q1.(n-1) fractional multiply, truncated toward -inf.
module pico_alu
  import pico_pkg::*;
#(
  parameter int n = 8
) (
  input  alu_func_t      func,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [n-1:0]   result
);

  logic signed [2*n-1:0] product;
  logic                  product_unused;

  assign product = $signed(a) * $signed(b);

  // The product has two sign bits and n-1 surplus fraction bits.
  // Only [2n-2:n-1] is kept.
  assign product_unused = ^{product[2*n-1], product[n-2:0]};

  always_comb begin
    result = b;
    unique case (func)
      ALU_PASS: result = b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_MUL:  result = product[2*n-2:n-1];
      default:  result = b;
    endcase
  end

endmodule

// File: rtl/pico_alu_decode_pc.sv
// pico_alu_decode_pc: the picoMIPS control-and-execute core.
// It contains the program counter, opcode decoder, operand mux and ALU.
// The program ROM and the register file are external.
// Ports:
//   clk       in  1     : clock, rising edge
//   reset     in  1     : synchronous active-high reset
//   go        in  1     : sw8 level, already synchronous to clk
//   sws       in  n     : switch data (loaded by LDSW)
//   instr     in  Isize : fetched instruction
//   rdata1    in  n     : register read data, port 1 (R1)
//   rdata2    in  n     : register read data, port 2 (R2)
//   prog_addr out Psize : program address (PC)
//   raddr1    out 3     : R1 field
//   raddr2    out 3     : R2 field, also the write-back address
//   wdata     out n     : ALU result
//   write     out 1     : register-file write enable
module pico_alu_decode_pc
  import pico_pkg::*;
#(
  parameter int n     = 8,
  parameter int Psize = 4,
  parameter int Isize = n + 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [n-1:0]     sws,
  input  logic [Isize-1:0] instr,
  input  logic [n-1:0]     rdata1,
  input  logic [n-1:0]     rdata2,
  output logic [Psize-1:0] prog_addr,
  output logic [2:0]       raddr1,
  output logic [2:0]       raddr2,
  output logic [n-1:0]     wdata,
  output logic             write
);

  opcode_t    opcode;
  alu_func_t  alu_func;
  logic       imm;
  logic       src;
  logic       write_dec;
  logic       pc_incr;
  logic [n-1:0] alu_b;

  logic [Psize-1:0] pc_q, pc_d;
  logic             go_q, go_d;
  logic             go_fall;

  // Field extraction
  assign opcode = opcode_t'(instr[Isize-1 -: OPC_W]);
  assign raddr1 = instr[Isize-1-R1_OFS -: REG_W];
  assign raddr2 = instr[Isize-1-R2_OFS -: REG_W];

  // Decoder
  always_comb begin
    alu_func  = ALU_PASS;
    imm       = 1'b0;
    src       = 1'b0;
    write_dec = 1'b0;
    pc_incr   = 1'b1;
    unique case (opcode)
      OP_NOP:  begin alu_func = ALU_PASS;                         write_dec = 1'b0; end
      OP_ADD:  begin alu_func = ALU_ADD;                          write_dec = 1'b1; end
      OP_ADDI: begin alu_func = ALU_ADD;  imm = 1'b1; src = 1'b1; write_dec = 1'b1; end
      OP_SUB:  begin alu_func = ALU_SUB;                          write_dec = 1'b1; end
      OP_MULI: begin alu_func = ALU_MUL;  imm = 1'b1; src = 1'b1; write_dec = 1'b1; end
      OP_MUL:  begin alu_func = ALU_MUL;                          write_dec = 1'b1; end
      OP_LDSW: begin alu_func = ALU_PASS; imm = 1'b1; src = 1'b0; write_dec = 1'b1; end
      OP_WAIT: begin alu_func = ALU_PASS; pc_incr = 1'b0;         write_dec = 1'b0; end
      default: begin end
    endcase
  end

  // Operand mux
  // Operand b comes from one of three sources:
  //   - rdata1 when imm=0
  //   - the immediate field when imm=1 and src=1
  //   - the switches when imm=1 and src=0
  always_comb begin
    alu_b = rdata1;
    if (imm) begin
      alu_b = src ? instr[n-1:0] : sws;
    end
  end

  pico_alu #(.n(n)) u_alu (
    .func   (alu_func),
    .a      (rdata2),
    .b      (alu_b),
    .result (wdata)
  );

  // The register file must never be written while the core is held in reset.
  assign write = write_dec & ~reset;

  // PC and go edge detect
  // A falling edge of go is only consulted while the current instruction is WAIT.
  // go_q is refreshed every cycle, so an edge seen during any other instruction is lost.
  assign go_fall = go_q & ~go;

  always_comb begin
    pc_d = pc_q;
    go_d = go;
    if (reset) begin
      pc_d = '0;
      go_d = 1'b0;
    end else if (pc_incr || ((opcode == OP_WAIT) && go_fall)) begin
      pc_d = pc_q + Psize'(1);  // natural wrap at 2^Psize
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    go_q <= go_d;
  end

  assign prog_addr = pc_q;

endmodule

// File: tb/tb_pico_alu_decode_pc.sv
// Directed self-checking bench for pico_alu_decode_pc (n=8, Psize=4, Isize=17).
module tb_pico_alu_decode_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  sws;
  logic [16:0] instr;
  logic [7:0]  rdata1;
  logic [7:0]  rdata2;
  logic [3:0]  prog_addr;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [7:0]  wdata;
  logic        write;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [2:0] NOP  = 3'b000, ADD  = 3'b001, ADDI = 3'b010, SUB  = 3'b011,
                         MULI = 3'b100, MUL  = 3'b101, LDSW = 3'b110, WAITI = 3'b111;

  always #5 clk = ~clk;

  pico_alu_decode_pc dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .sws       (sws),
    .instr     (instr),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .prog_addr (prog_addr),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .wdata     (wdata),
    .write     (write)
  );

  function automatic logic [16:0] mk(input logic [2:0] op, input logic [2:0] r1,
                                     input logic [2:0] r2, input logic [7:0] imm8);
    return {op, r1, r2, imm8};
  endfunction

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; sws = 8'h00; rdata1 = 8'h11; rdata2 = 8'h22;
    instr = mk(ADD, 3'd1, 3'd2, 8'h00);
    tick(); tick();
    tests_run++;
    if (prog_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_pc: got %0d expected 0", prog_addr);
    end
    tests_run++;
    if (write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_write: got %b expected 0", write);
    end
    $display("[TB] reset: prog_addr=%0d write=%b", prog_addr, write);
    reset = 1'b0;
  endtask

  task automatic test_increment_wrap();
    instr = mk(NOP, 3'd0, 3'd0, 8'h00);
    for (int i = 0; i <= 16; i++) begin
      tests_run++;
      if (prog_addr !== 4'(i % 16) || write !== 1'b0) begin
        tests_failed++;
        $display("FAIL nop_pc_%0d: got pc=%0d write=%b expected pc=%0d write=0",
                 i, prog_addr, write, i % 16);
      end
      $display("[TB] nop step %0d: prog_addr=%0d write=%b", i, prog_addr, write);
      tick();
    end
  endtask

  task automatic test_alu();
    // ADDI 0x05 + 0x03
    rdata2 = 8'h05; rdata1 = 8'h77; instr = mk(ADDI, 3'd4, 3'd3, 8'h03); #1;
    tests_run++;
    if (wdata !== 8'h08 || write !== 1'b1) begin
      tests_failed++;
      $display("FAIL addi: got wdata=%h write=%b expected 08 1", wdata, write);
    end
    $display("[TB] ADDI: wdata=%h write=%b", wdata, write);
    // ADDI wrap: 0xFF + 0x02 = 0x01
    rdata2 = 8'hFF; instr = mk(ADDI, 3'd0, 3'd1, 8'h02); #1;
    tests_run++;
    if (wdata !== 8'h01) begin
      tests_failed++;
      $display("FAIL addi_wrap: got %h expected 01", wdata);
    end
    $display("[TB] ADDI wrap: wdata=%h", wdata);
    // SUB 0x02 - 0x05
    rdata2 = 8'h02; rdata1 = 8'h05; instr = mk(SUB, 3'd5, 3'd6, 8'h99); #1;
    tests_run++;
    if (wdata !== 8'hFD || write !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub: got wdata=%h write=%b expected FD 1", wdata, write);
    end
    $display("[TB] SUB: wdata=%h write=%b", wdata, write);
    // ADD register: 0x30 + 0x12, immediate field ignored
    rdata2 = 8'h30; rdata1 = 8'h12; instr = mk(ADD, 3'd2, 3'd7, 8'hF0); #1;
    tests_run++;
    if (wdata !== 8'h42 || raddr1 !== 3'd2 || raddr2 !== 3'd7) begin
      tests_failed++;
      $display("FAIL add: got wdata=%h r1=%0d r2=%0d expected 42 2 7", wdata, raddr1, raddr2);
    end
    $display("[TB] ADD: wdata=%h raddr1=%0d raddr2=%0d", wdata, raddr1, raddr2);
    // LDSW 0xA5
    sws = 8'hA5; rdata1 = 8'h3C; rdata2 = 8'h0F; instr = mk(LDSW, 3'd1, 3'd5, 8'h5A); #1;
    tests_run++;
    if (wdata !== 8'hA5 || write !== 1'b1 || raddr2 !== 3'd5) begin
      tests_failed++;
      $display("FAIL ldsw: got wdata=%h write=%b r2=%0d expected A5 1 5", wdata, write, raddr2);
    end
    $display("[TB] LDSW: wdata=%h write=%b raddr2=%0d", wdata, write, raddr2);
    // MULI 0.5 * 0.5 = 0.25
    rdata2 = 8'h40; instr = mk(MULI, 3'd0, 3'd2, 8'h40); #1;
    tests_run++;
    if (wdata !== 8'h20 || write !== 1'b1) begin
      tests_failed++;
      $display("FAIL muli_pos: got wdata=%h write=%b expected 20 1", wdata, write);
    end
    $display("[TB] MULI +: wdata=%h", wdata);
    // MULI -0.5 * 0.5 = -0.25
    rdata2 = 8'hC0; instr = mk(MULI, 3'd0, 3'd2, 8'h40); #1;
    tests_run++;
    if (wdata !== 8'hE0) begin
      tests_failed++;
      $display("FAIL muli_neg: got %h expected E0", wdata);
    end
    $display("[TB] MULI -: wdata=%h", wdata);
    // MUL register: -0.5 * -0.5 = 0.25 (b from rdata1)
    rdata2 = 8'hC0; rdata1 = 8'hC0; instr = mk(MUL, 3'd3, 3'd4, 8'h7F); #1;
    tests_run++;
    if (wdata !== 8'h20) begin
      tests_failed++;
      $display("FAIL mul_reg: got %h expected 20", wdata);
    end
    $display("[TB] MUL: wdata=%h", wdata);
    // NOP: pass b, no write
    rdata1 = 8'h9C; instr = mk(NOP, 3'd6, 3'd1, 8'h00); #1;
    tests_run++;
    if (wdata !== 8'h9C || write !== 1'b0 || raddr1 !== 3'd6) begin
      tests_failed++;
      $display("FAIL nop_out: got wdata=%h write=%b r1=%0d expected 9C 0 6", wdata, write, raddr1);
    end
    $display("[TB] NOP: wdata=%h write=%b", wdata, write);
  endtask

  task automatic test_wait_go();
    reset = 1'b1; go = 1'b0; instr = mk(NOP, 3'd0, 3'd0, 8'h00);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (prog_addr !== 4'd3) begin
      tests_failed++;
      $display("FAIL pc_before_wait: got %0d expected 3", prog_addr);
    end
    instr = mk(WAITI, 3'd0, 3'd0, 8'h00); #1;
    tests_run++;
    if (write !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_write: got %b expected 0", write);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (prog_addr !== 4'd3) begin
        tests_failed++;
        $display("FAIL wait_hold_%0d: got %0d expected 3", i, prog_addr);
      end
    end
    $display("[TB] WAIT held 10 cycles: prog_addr=%0d", prog_addr);
    go = 1'b1;
    tick();
    tests_run++;
    if (prog_addr !== 4'd3) begin
      tests_failed++;
      $display("FAIL wait_go_high: got %0d expected 3", prog_addr);
    end
    go = 1'b0;
    tick();
    tests_run++;
    if (prog_addr !== 4'd4) begin
      tests_failed++;
      $display("FAIL wait_release: got %0d expected 4", prog_addr);
    end
    $display("[TB] go fall released WAIT: prog_addr=%0d", prog_addr);
    // go stays low: a WAIT at 4 must not see a stale edge
    tick(); tick();
    tests_run++;
    if (prog_addr !== 4'd4) begin
      tests_failed++;
      $display("FAIL wait_low_hold: got %0d expected 4", prog_addr);
    end
    // Falling edge during NOPs is forgotten
    instr = mk(NOP, 3'd0, 3'd0, 8'h00); go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tests_run++;
    if (prog_addr !== 4'd6) begin
      tests_failed++;
      $display("FAIL nop_with_go: got %0d expected 6", prog_addr);
    end
    instr = mk(WAITI, 3'd0, 3'd0, 8'h00);
    tick(); tick(); tick();
    tests_run++;
    if (prog_addr !== 4'd6) begin
      tests_failed++;
      $display("FAIL wait_after_nop_edge: got %0d expected 6", prog_addr);
    end
    $display("[TB] edge during NOP not remembered: prog_addr=%0d", prog_addr);
  endtask

  task automatic test_reset_in_wait();
    // Arm a falling edge so the WAIT would advance, then reset takes priority.
    go = 1'b1;
    tick();
    go = 1'b0; reset = 1'b1;
    tick();
    tests_run++;
    if (prog_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_in_wait: got %0d expected 0", prog_addr);
    end
    $display("[TB] reset during WAIT: prog_addr=%0d", prog_addr);
    reset = 1'b0;
    instr = mk(NOP, 3'd0, 3'd0, 8'h00);
    tick();
    tests_run++;
    if (prog_addr !== 4'd1) begin
      tests_failed++;
      $display("FAIL post_reset_run: got %0d expected 1", prog_addr);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_increment_wrap();
    test_alu();
    test_wait_go();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pico_alu_decode_pc.md
# pico_alu_decode_pc

Control-and-execute core of the picoMIPS affine-transform processor: program counter, opcode decoder, operand multiplexer and ALU in one block. It sits between the external program ROM and register file, neither of which it contains. It emits the program address and register read addresses, and takes back the fetched instruction and register read data. It produces the write-back value and write strobe.

## Interface
- `n`, default 8: data width.
- `Psize`, default 4: program address width (16 instructions).
- `Isize`, default `n+9`: instruction width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `go` in 1: switch sw8 level. Already synchronised to `clk` upstream.
- `sws` in n: switch data input (x1/y1).
- `instr` in Isize: fetched instruction.
- `rdata1` in n: register read port 1 data.
- `rdata2` in n: register read port 2 data.
- `prog_addr` out Psize: program address.
- `raddr1` out 3: equals `instr[Isize-4:Isize-6]`.
- `raddr2` out 3: equals `instr[Isize-7:Isize-9]`. This field is also the write address.
- `wdata` out n: ALU result.
- `write` out 1: register-file write enable.

## Operation
- **Instruction format:** opcode `[Isize-1:Isize-3]`, R1 field next, R2 field next, immediate `[n-1:0]`.
- **ALU operands:** `a = rdata2`. `b` is selected as follows:
  - `rdata1` when imm=0.
  - `instr[n-1:0]` when imm=1 and src=1.
  - `sws` when imm=1 and src=0.
- **ALUFunc (2 bits):**
  - 00: pass b.
  - 01: a+b, modulo 2^n.
  - 10: a−b, modulo 2^n.
  - 11: signed fractional multiply. Form the 2n-bit signed product a×b; result = product `[2n-2:n-1]` (Q1.(n-1) format, truncated).
- **Decoder table** (opcode: ALUFunc, imm, src, write, pc_incr):
  - 000 NOP: 00, 0, x, 0, 1.
  - 001 ADD: 01, 0, x, 1, 1.
  - 010 ADDI: 01, 1, 1, 1, 1.
  - 011 SUB: 10, 0, x, 1, 1.
  - 100 MULI: 11, 1, 1, 1, 1.
  - 101 MUL: 11, 0, x, 1, 1.
  - 110 LDSW: 00, 1, 0, 1, 1. Loads the switches into R2.
  - 111 WAIT: 00, 0, x, 0, 0. Waits for a `go` falling edge.
- **PC:** advances by 1 on `clk` when pc_incr=1, or when the instruction is WAIT and a `go` falling edge is detected (`go_q`=1, `go`=0). Otherwise holds.
- **Wrap:** PC wraps from 2^Psize−1 to 0.
- **`go_q`:** registered copy of `go`. Updated every cycle.

## Timing
- On reset: `prog_addr`=0 and `go_q`=0. `write` is forced to 0 in any cycle where `reset` is high.
- `wdata`, `write`, `raddr1` and `raddr2` are combinational from `instr` and data inputs; zero-cycle latency.
- PC update is one cycle: the instruction at address k executes in the cycle where `prog_addr`=k.
- **`go` edge handling:**
  - A falling edge of `go` that arrives while the current instruction is not WAIT is ignored; it is not remembered.
  - Inside WAIT, `go` held low stalls forever until a new high→low transition occurs.
- **Reset priority:** reset asserted mid-program has priority over any increment; the PC returns to 0 the same edge.

## Structure
- **Shared package `pico_pkg`:**
  - opcode enum (NOP, ADD, ADDI, SUB, MULI, MUL, LDSW, WAIT).
  - ALUFunc enum (PASS, ADD, SUB, MUL).
  - field-position constants.
- **Sub-modules:** `pico_alu` (purely combinational ALU), decoder (`always_comb` case), PC register with edge detect, and operand mux. These are instantiated or written inline in the top block.

## Test plan
- **Reset / increment / wrap:** reset high 2 cycles, then NOP stream → `prog_addr` 0,1,2…15,0 (wraps); `write`=0 throughout.
- **ADDI and SUB:** ADDI with rdata2=0x05, imm=0x03 → `wdata`=0x08, `write`=1. SUB with rdata2=0x02, rdata1=0x05 → `wdata`=0xFD.
- **LDSW:** LDSW with `sws`=0xA5 → `wdata`=0xA5, `write`=1, `raddr2`=`instr[10:8]`.
- **MULI:** MULI with rdata2=0x40 (0.5) and imm=0x40 → `wdata`=0x20. With rdata2=0xC0 (−0.5) and imm=0x40 → `wdata`=0xE0.
- **WAIT / go:** WAIT at address 3 with `go` low → PC holds at 3 for 10 cycles. Raise `go` 1 cycle, then lower → PC=4 on the next edge. A falling edge on `go` during a NOP does not skip a later WAIT.
- **Reset while waiting:** reset during WAIT → `prog_addr`=0 on the next edge.
